muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit that owns the HI/LO register pair read by the ALU's mfhi/mflo path.
//  Accepts mult/multu/div/divu from the decode stage with a Start pulse.
//  Iterates one bit per clock: shift-add for multiply, restoring division for divide.
//  Writes the 2*dataWidth result into HI/LO. Stalls the pipeline through Busy.
// PARAMETERS
//  dataWidth  32  operand width; HI and LO are each dataWidth bits
// PORTS
//  clk         in   1            rising-edge clock
//  rst_n       in   1            asynchronous, active-low reset
//  Start       in   1            one-cycle request; sampled only when not Busy
//  Op          in   2            00 mult, 01 multu, 10 div, 11 divu
//  SrcA        in   dataWidth    multiplicand / dividend
//  SrcB        in   dataWidth    multiplier / divisor
//  Busy        out  1            high while iterating; the decode stage stalls mfhi/mflo on it
//  Done        out  1            one-cycle pulse; HI/LO are valid from this cycle
//  DivByZero   out  1            valid with Done; high for div/divu with SrcB==0
//  HI          out  dataWidth    mult: upper product; div: remainder
//  LO          out  dataWidth    mult: lower product; div: quotient
// BEHAVIOUR
//  - One clock domain, clk. rst_n is asynchronous and active-low.
//  - Reset, including mid-operation: state=IDLE, Busy=0, Done=0, DivByZero=0, HI=0, LO=0,
//    and the counter and working registers are cleared. An in-flight operation is discarded.
//  - States:
//      IDLE --Start--> RUN
//      RUN --count==dataWidth--> DONE
//      DONE --Start--> RUN, else --> IDLE
//  - Edge E0 (Start accepted in IDLE/DONE): latch Op, |SrcA|, |SrcB| and the result sign; count=0.
//    Signed ops take magnitudes; unsigned ops take the raw values.
//  - Edges E1..E(dataWidth): one iteration each.
//  - Edge E(dataWidth+1): apply sign correction, write HI/LO, enter DONE.
//    Done is high for exactly 1 cycle; latency Start->Done = dataWidth+1 clocks.
//  - Busy is high in RUN only. Start while Busy is ignored: no restart, no effect on the result.
//  - HI/LO hold their value except on the RUN->DONE edge.
//    The ALU may read HI/LO at any time when Busy=0.
//  - mult: signed product, two's complement across {HI,LO}.
//  - div: quotient truncates toward zero; the remainder takes the dividend's sign.
//    Overflow case -2^(dataWidth-1) / -1: LO=0x80000000, HI=0, DivByZero=0.
//  - Divide by zero (div or divu): LO = all ones, HI = SrcA unmodified, DivByZero=1.
//    Takes the full latency.
//  - DivByZero=0 for mult/multu. It is cleared when the next Start is accepted.
//  - Op encodings are all defined, so no illegal-op case exists.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   - mult/multu leave RUN as soon as the remaining multiplier magnitude is 0,
//     after at least 1 iteration.
//   - Latency = k+1 clocks, where k = bit length of |SrcB| (k=1 when SrcB=0).
//   - Divide latency is unchanged.
//  Not defined: every operation takes a fixed dataWidth+1 clocks.
// TESTING
//  1 multu 0xFFFFFFFF*0xFFFFFFFF -> Done at E33; HI=FFFFFFFE, LO=00000001; Busy high E0..E33.
//  2 mult -3*5 -> HI=FFFFFFFF, LO=FFFFFFF1.
//  3 div -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//    div 0x80000000/0xFFFFFFFF -> LO=80000000, HI=0.
//  4 divu 0x1234/0 -> LO=FFFFFFFF, HI=00001234, DivByZero=1 for the Done cycle only.
//  5 Start for a new op at E5 of a running op -> ignored; original result lands at E33.
//    rst_n low at E10 -> Busy=0 and HI=LO=0 immediately, no Done.
//  6 MULDIV_EARLY_OUT_EN: multu 5*3 -> Done 3 clocks after Start, LO=0000000F.
//    Same stimulus without the macro -> Done at 33 clocks.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit that owns the HI/LO pair.
//   mult/multu use shift-add and div/divu use restoring division, one bit per clock.
//   Signed operations run on magnitudes. The sign is corrected on the final edge.
//   Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
//   finishes once the remaining multiplier bits are all zero.
module muldiv_unit #(
   parameter int unsigned dataWidth = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [dataWidth-1:0] SrcA,
   input  logic [dataWidth-1:0] SrcB,
   output logic                 Busy,
   output logic                 Done,
   output logic                 DivByZero,
   output logic [dataWidth-1:0] HI,
   output logic [dataWidth-1:0] LO
);

   localparam int unsigned W  = dataWidth;
   localparam int unsigned CW = $clog2(dataWidth + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   count;
   logic            is_div;     // latched Op[1]
   logic            res_neg;    // product / quotient must be negated
   logic            rem_neg;    // remainder takes the dividend's sign
   logic [2*W-1:0]  acc;        // mult: running product; div: {remainder, quotient}
   logic [2*W-1:0]  mcand;      // mult: multiplicand, shifted left each step
   logic [W-1:0]    mplier;     // mult: multiplier, shifted right; div: divisor

   logic            accept, last_iter, op_signed, div_zero;
   logic [W-1:0]    a_mag, b_mag;
   logic [W:0]      part_rem;
   logic [W-1:0]    sub_rem, quo_fix, rem_fix;
   logic [2*W-1:0]  prod_fix;

   // Operand conditioning, the divide step and the final sign correction
   always_comb begin
      op_signed = ~Op[0];
      a_mag     = (op_signed && SrcA[W-1]) ? -SrcA : SrcA;
      b_mag     = (op_signed && SrcB[W-1]) ? -SrcB : SrcB;
      // The partial remainder is {rem, next dividend bit}. The low W bits of the
      // difference are exact whenever the subtraction is taken.
      part_rem  = acc[2*W-1:W-1];
      sub_rem   = part_rem[W-1:0] - mplier;
      div_zero  = (mplier == '0);
      prod_fix  = res_neg ? -acc : acc;
      quo_fix   = res_neg ? -acc[W-1:0] : acc[W-1:0];
      rem_fix   = rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W];
`ifdef MULDIV_EARLY_OUT_EN
      last_iter = (count == CW'(W)) || (!is_div && (count != '0) && (mplier == '0));
`else
      last_iter = (count == CW'(W));
`endif
   end

   // Next-state logic and Start acceptance
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_iter) state_nxt = DONE;
         end
         DONE: begin
            if (Start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand latch, iteration datapath and HI/LO write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         is_div    <= 1'b0;
         res_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         DivByZero <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else if (accept) begin
         count     <= '0;
         is_div    <= Op[1];
         res_neg   <= op_signed & (SrcA[W-1] ^ SrcB[W-1]);
         rem_neg   <= op_signed & SrcA[W-1];
         acc       <= Op[1] ? {{W{1'b0}}, a_mag} : '0;
         mcand     <= {{W{1'b0}}, a_mag};
         mplier    <= b_mag;
         DivByZero <= 1'b0;
      end else if (state == RUN) begin
         if (!last_iter) begin
            count <= count + CW'(1);
            if (is_div) begin
               if (part_rem >= {1'b0, mplier})
                  acc <= {sub_rem, acc[W-2:0], 1'b1};
               else
                  acc <= {acc[2*W-2:0], 1'b0};
            end else begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= {mcand[2*W-2:0], 1'b0};
               mplier <= {1'b0, mplier[W-1:1]};
            end
         end else begin
            DivByZero <= is_div & div_zero;
            if (!is_div) begin
               HI <= prod_fix[2*W-1:W];
               LO <= prod_fix[W-1:0];
            end else if (div_zero) begin
               // Dividing by zero leaves the raw dividend in the remainder half.
               // Restoring its sign gives back SrcA unmodified.
               HI <= rem_fix;
               LO <= '1;
            end else begin
               HI <= rem_fix;
               LO <= quo_fix;
            end
         end
      end else if (state == DONE) begin
         DivByZero <= 1'b0;
      end
   end

   assign Busy = (state == RUN);
   assign Done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
//   Build with MULDIV_EARLY_OUT_EN to match the early-out variant of the RTL.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] SrcA, SrcB;
   logic        Busy, Done, DivByZero;
   logic [31:0] HI, LO;

   int vec_cnt = 0;
   int err_cnt = 0;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_5X3 = 3;
`else
   localparam int LAT_5X3 = 33;
`endif

   muldiv_unit #(.dataWidth(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Start     (Start),
      .Op        (Op),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one operation from IDLE and follow it until Done (bounded).
   // An exp_lat of 0 skips the latency comparison.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dbz, input int exp_lat);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      Start = 1'b1; Op = op; SrcA = a; SrcB = b;
      @(posedge clk); #1;
      Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
      lat = 0; busy_ok = 1'b1;
      while (!Done && lat < 200) begin
         if (!Busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, ".done"}, 64'(Done), 64'd1);
      if (exp_lat != 0) check_val({tag, ".lat"}, 64'(lat), 64'(exp_lat));
      check_val({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
      check_val({tag, ".busy_done"}, 64'(Busy), 64'd0);
      check_val({tag, ".hi"}, 64'(HI), 64'(exp_hi));
      check_val({tag, ".lo"}, 64'(LO), 64'(exp_lo));
      check_val({tag, ".dbz"}, 64'(DivByZero), 64'(exp_dbz));
      @(posedge clk); #1;
      check_val({tag, ".done_pulse"}, 64'(Done), 64'd0);
      check_val({tag, ".dbz_clr"}, 64'(DivByZero), 64'd0);
      check_val({tag, ".hi_hold"}, 64'(HI), 64'(exp_hi));
   endtask

   initial begin
      int lat;
      int dones;
      rst_n = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
      #12;
      check_val("rst.busy", 64'(Busy), 64'd0);
      check_val("rst.done", 64'(Done), 64'd0);
      check_val("rst.dbz", 64'(DivByZero), 64'd0);
      check_val("rst.hi", 64'(HI), 64'd0);
      check_val("rst.lo", 64'(LO), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
      run_op("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
      run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0);
      run_op("mult_minx1", 2'b00, 32'h80000000, 32'd1,       32'hFFFFFFFF, 32'h80000000, 1'b0, 0);
      run_op("multu_5x3", 2'b01, 32'd5, 32'd3,               32'h00000000, 32'h0000000F, 1'b0, LAT_5X3);
      run_op("div_m7d2",  2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
      run_op("div_7dm2",  2'b10, 32'd7, 32'hFFFFFFFE,        32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
      run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
      run_op("divu_100d7", 2'b11, 32'd100, 32'd7,            32'h00000002, 32'h0000000E, 1'b0, 33);
      run_op("divu_dz",   2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 33);
      run_op("div_dz",    2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 33);

      // A Start arriving at E5 of a running multiply must not restart it
      @(negedge clk);
      Start = 1'b1; Op = 2'b01; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF;
      @(posedge clk); #1;
      Start = 1'b0;
      lat = 0;
      while (!Done && lat < 200) begin
         if (lat == 4) begin Start = 1'b1; Op = 2'b10; SrcA = 32'd7; SrcB = 32'd0; end
         if (lat == 5) Start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check_val("ign.lat", 64'(lat), 64'd33);
      check_val("ign.hi", 64'(HI), 64'hFFFFFFFE);
      check_val("ign.lo", 64'(LO), 64'h00000001);
      check_val("ign.dbz", 64'(DivByZero), 64'd0);
      @(posedge clk); #1;

      // Asynchronous reset at E10 discards the operation in flight
      @(negedge clk);
      Start = 1'b1; Op = 2'b11; SrcA = 32'd100; SrcB = 32'd7;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("arst.busy", 64'(Busy), 64'd0);
      check_val("arst.done", 64'(Done), 64'd0);
      check_val("arst.hi", 64'(HI), 64'd0);
      check_val("arst.lo", 64'(LO), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (Done || Busy) dones++;
      end
      check_val("arst.no_done", 64'(dones), 64'd0);

      run_op("recover", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
